video_sync_norm: RTL and testbench
==================================

Name: video_sync_norm

Overview:
- Sync-normalisation stage directly upstream of the analog/VGA output stage. Consumes raw core video (sync of arbitrary polarity, data enable, RGB888).
- Measures horizontal and vertical sync polarity at run time and re-emits sync in fixed active-low form, plus an XOR-serrated composite sync.
- Forces RGB to black outside active video.
- Drives the output stage's hsync/vsync/csync/din inputs with equal latency on all paths.

Parameters:
- CNT_W, 12, width of saturating phase-length counters (pixels for H, lines for V).
- BLANK_EN, 1, 1 = zero RGB when de=0; 0 = pass RGB unmodified.

Ports:
- clk  in  1  video clock
- rst_n  in  1  asynchronous active-low reset
- ce_pix  in  1  pixel clock enable; measurement advances only when 1
- hsync  in  1  raw horizontal sync, unknown polarity
- vsync  in  1  raw vertical sync, unknown polarity
- de  in  1  data enable, active-high
- din  in  24  RGB888 {R,G,B}
- dout  out  24  blanked RGB888
- hsync_o  out  1  hsync, active-low
- vsync_o  out  1  vsync, active-low
- csync_o  out  1  composite sync, active-low
- h_pol  out  1  detected H polarity, 1 = active-high input
- v_pol  out  1  detected V polarity, 1 = active-high input
- locked  out  1  both polarities measured and stable

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - dout = 0; hsync_o = vsync_o = csync_o = 1.
  - h_pol = v_pol = 0; locked = 0.
  - All counters, stored lengths and candidate flags cleared.
- Edge detection:
  - hs_d and vs_d are registered copies of hsync/vsync, updated only on ce_pix = 1.
  - Edges are evaluated only when ce_pix = 1.
- H measurement:
  - hi_cnt counts ce_pix cycles with hsync = 1; lo_cnt counts ce_pix cycles with hsync = 0.
  - Both counters saturate at 2^CNT_W-1.
  - Falling edge: latch hi_len <= hi_cnt, clear hi_cnt.
  - Rising edge: latch lo_len <= lo_cnt, clear lo_cnt, then evaluate a candidate polarity, cand = (hi_len < lo_len).
  - Equal lengths: cand = current h_pol (no change).
- V measurement: identical, counting hsync rising edges (lines) instead of pixels.
- Hysteresis, per axis:
  - A 1-bit "pending" flag.
  - cand == pol: clear pending.
  - cand != pol with pending = 0: set pending.
  - cand != pol with pending = 1: pol <= cand, clear pending. Flip only on the 2nd consecutive disagreeing measurement.
- locked:
  - Set once each axis has completed at least 2 rising-edge evaluations.
  - Cleared when any counter reaches saturation (sync lost). Polarity holds its last value.
  - Re-arms after 2 fresh evaluations per axis.
- Active-level normalisation (combinational from registered state):
  - hs_act = hsync ^ ~h_pol; vs_act = vsync ^ ~v_pol.
- Output pipeline: fixed 2 clk cycles latency for dout, hsync_o, vsync_o, csync_o. Advances every clk, independent of ce_pix.
  - Stage 1 registers hs_act, vs_act, de, din.
  - Stage 2 drives:
    - hsync_o = ~hs_act1
    - vsync_o = ~vs_act1
    - csync_o = ~(hs_act1 ^ vs_act1), giving serration during vsync
    - dout = (BLANK_EN && !de1) ? 0 : din1
- Polarity change mid-frame: takes effect at the next stage-1 register. No glitch-suppression beyond the pipeline.
- Reset mid-frame: outputs go inactive immediately (async); measurement restarts from zero.
- Simultaneous hsync and vsync edges on the same ce_pix: H evaluation and V line-count both use the same edge. The V rising edge samples the line counter before its increment.

Decomposition:
- Shared package video_pkg:
  - CNT_W default
  - RGB888 typedef (struct r,g,b of 8 bits)
  - SYNC_ACTIVE_LOW constant
- One natural sub-module, sync_pol_detect. Instantiate twice: H with inc = ce_pix, V with inc = hsync rising edge.
  - Ports: clk, rst_n, ce, inc, sig, pol, valid, lost.
  - Contains the counters, length latches, hysteresis and evaluation count.
- Top level holds the normalisation, csync generation, blanking and 2-stage pipeline.

Test Plan:
- Reset, then 640x480 timing with active-low hsync (96 low / 704 high) and vsync (2 lines low / 523 high), ce_pix = 1:
  - After 2 lines, h_pol = 0; after 2 frames, v_pol = 0 and locked = 1.
  - hsync_o tracks input hsync delayed by exactly 2 clk.
- Same timing with both syncs inverted (active-high):
  - h_pol = 1 after the 2nd line, v_pol = 1 after the 2nd frame.
  - hsync_o low for 96 pixels per line, delayed by 2 clk.
- Single corrupted line (hsync high phase shortened to 1 pixel) inside stable active-low sync:
  - h_pol remains 0 (hysteresis); pending sets then clears.
- csync during vsync:
  - With vs_act = 1 and hs_act = 1, csync_o = 1.
  - With vs_act = 1 and hs_act = 0, csync_o = 0.
  - Outside vsync, csync_o == hsync_o.
- Blanking:
  - de = 0 with din = 24'hFFFFFF gives dout = 0 two cycles later.
  - de = 1 with din = 24'h123456 gives dout = 24'h123456. With BLANK_EN = 0 the de = 0 case also passes through.
- Hold hsync constant for 4096 ce_pix cycles:
  - locked drops to 0; h_pol holds its value.
  - Restoring timing re-asserts locked after 2 lines/frames.
- Assert rst_n low mid-line: outputs read 1/1/1/0 immediately, with no clk edge needed.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and constants for the video sync-normalisation path.
package video_pkg;
  localparam int CNT_W_DEF = 12;
  // Level driven on an output sync line while that sync is asserted
  localparam logic SYNC_ACTIVE_LOW = 1'b0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;
endpackage

// File: rtl/sync_pol_detect.sv
// Measures high/low phase lengths of one sync signal and infers its asserted
// polarity with two-measurement hysteresis.
module sync_pol_detect
  import video_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic inc,
  input  logic sig,
  output logic pol,
  output logic valid,
  output logic lost
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_sig_d, r_eval, r_pend, r_pol;
  logic [CNT_W-1:0] r_hi_cnt, r_lo_cnt, r_hi_len, r_lo_len;
  logic [1:0]       r_evals;
  logic             w_rise, w_fall, w_cand;

  assign w_rise = ce & sig & ~r_sig_d;
  assign w_fall = ce & ~sig & r_sig_d;
  // The shorter phase is the asserted one; a tie keeps the current polarity
  assign w_cand = (r_hi_len < r_lo_len) ? 1'b1 :
                  (r_hi_len > r_lo_len) ? 1'b0 : r_pol;
  assign lost   = (r_hi_cnt == CNT_MAX) || (r_lo_cnt == CNT_MAX);
  assign valid  = (r_evals == 2'd2);
  assign pol    = r_pol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_d  <= 1'b0;
      r_eval   <= 1'b0;
      r_pend   <= 1'b0;
      r_pol    <= 1'b0;
      r_hi_cnt <= '0;
      r_lo_cnt <= '0;
      r_hi_len <= '0;
      r_lo_len <= '0;
      r_evals  <= '0;
    end else begin
      if (ce) r_sig_d <= sig;
      if (w_fall)                             r_hi_cnt <= '0;
      else if (inc && sig && r_hi_cnt != CNT_MAX)  r_hi_cnt <= r_hi_cnt + 1'b1;
      if (w_rise)                             r_lo_cnt <= '0;
      else if (inc && !sig && r_lo_cnt != CNT_MAX) r_lo_cnt <= r_lo_cnt + 1'b1;
      if (w_fall) r_hi_len <= r_hi_cnt;
      if (w_rise) r_lo_len <= r_lo_cnt;
      // Evaluate one cycle after the rising edge, once lo_len holds the new length
      r_eval <= w_rise;
      if (r_eval) begin
        if (w_cand == r_pol) r_pend <= 1'b0;
        else if (!r_pend)    r_pend <= 1'b1;
        else begin
          r_pol  <= w_cand;
          r_pend <= 1'b0;
        end
      end
      if (lost)                          r_evals <= '0;
      else if (r_eval && r_evals != 2'd2) r_evals <= r_evals + 2'd1;
    end
  end
endmodule

// File: rtl/video_sync_norm.sv
// Sync polarity normalisation, composite sync and RGB blanking ahead of the
// analog output stage; all outputs share a fixed 2-cycle latency.
module video_sync_norm
  import video_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter bit BLANK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_pix,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  input  logic [23:0] din,
  output logic [23:0] dout,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        csync_o,
  output logic        h_pol,
  output logic        v_pol,
  output logic        locked
);
  logic        r_hs_d, r_locked;
  logic        r_hs_act1, r_vs_act1, r_de1;
  rgb888_t     r_din1;
  logic        r_hsync_o, r_vsync_o, r_csync_o;
  logic [23:0] r_dout;
  logic        w_hs_rise, w_hs_act, w_vs_act;
  logic        w_h_valid, w_v_valid, w_h_lost, w_v_lost;

  // Vertical phases are measured in lines, one per raw hsync rising edge
  assign w_hs_rise = ce_pix & hsync & ~r_hs_d;

  sync_pol_detect #(.CNT_W(CNT_W)) u_h (
    .clk(clk), .rst_n(rst_n), .ce(ce_pix), .inc(ce_pix), .sig(hsync),
    .pol(h_pol), .valid(w_h_valid), .lost(w_h_lost)
  );

  sync_pol_detect #(.CNT_W(CNT_W)) u_v (
    .clk(clk), .rst_n(rst_n), .ce(ce_pix), .inc(w_hs_rise), .sig(vsync),
    .pol(v_pol), .valid(w_v_valid), .lost(w_v_lost)
  );

  assign w_hs_act = hsync ^ ~h_pol;
  assign w_vs_act = vsync ^ ~v_pol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_d    <= 1'b0;
      r_locked  <= 1'b0;
      r_hs_act1 <= 1'b0;
      r_vs_act1 <= 1'b0;
      r_de1     <= 1'b0;
      r_din1    <= '0;
      r_hsync_o <= 1'b1;
      r_vsync_o <= 1'b1;
      r_csync_o <= 1'b1;
      r_dout    <= '0;
    end else begin
      if (ce_pix) r_hs_d <= hsync;
      r_locked  <= w_h_valid & w_v_valid & ~w_h_lost & ~w_v_lost;
      r_hs_act1 <= w_hs_act;
      r_vs_act1 <= w_vs_act;
      r_de1     <= de;
      r_din1    <= din;
      r_hsync_o <= r_hs_act1 ? SYNC_ACTIVE_LOW : ~SYNC_ACTIVE_LOW;
      r_vsync_o <= r_vs_act1 ? SYNC_ACTIVE_LOW : ~SYNC_ACTIVE_LOW;
      // XOR gives the serrated composite: hsync pulses invert inside vsync
      r_csync_o <= (r_hs_act1 ^ r_vs_act1) ? SYNC_ACTIVE_LOW : ~SYNC_ACTIVE_LOW;
      r_dout    <= (BLANK_EN && !r_de1) ? 24'h0 : r_din1;
    end
  end

  assign hsync_o = r_hsync_o;
  assign vsync_o = r_vsync_o;
  assign csync_o = r_csync_o;
  assign dout    = r_dout;
  assign locked  = r_locked;
endmodule

// File: tb/tb_video_sync_norm.sv
// Directed bench for video_sync_norm using a shrunken raster
// (8-pixel hsync pulse in a 32-pixel line, 2-line vsync in a 15-line frame).
module tb_video_sync_norm;
  logic        clk = 1'b0;
  logic        rst_n, ce_pix, hsync, vsync, de;
  logic [23:0] din;
  logic [23:0] dout, dout_nb;
  logic        hsync_o, vsync_o, csync_o, h_pol, v_pol, locked;
  logic        nb_hs, nb_vs, nb_cs, nb_hp, nb_vp, nb_lk;

  int   tests = 0;
  int   fails = 0;
  int   trk_err;
  logic hist1, hist2;

  always #5 clk = ~clk;

  video_sync_norm #(.CNT_W(12), .BLANK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ce_pix(ce_pix), .hsync(hsync), .vsync(vsync),
    .de(de), .din(din), .dout(dout), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .csync_o(csync_o), .h_pol(h_pol), .v_pol(v_pol), .locked(locked)
  );

  video_sync_norm #(.CNT_W(12), .BLANK_EN(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ce_pix(ce_pix), .hsync(hsync), .vsync(vsync),
    .de(de), .din(din), .dout(dout_nb), .hsync_o(nb_hs), .vsync_o(nb_vs),
    .csync_o(nb_cs), .h_pol(nb_hp), .v_pol(nb_vp), .locked(nb_lk)
  );

  // One pixel: sample outputs just after the edge, then drive the next inputs.
  // With trk set, hsync_o must equal the hsync driven two pixels earlier, xor inv.
  task automatic pix(input logic h, input logic v, input logic d,
                     input logic [23:0] px, input bit trk, input logic inv);
    @(posedge clk); #1;
    if (trk && (hsync_o !== (hist2 ^ inv))) trk_err++;
    hsync = h; vsync = v; de = d; din = px;
    hist2 = hist1; hist1 = h;
  endtask

  task automatic line(input logic act_hi, input logic v, input int sync_px,
                      input int rest_px, input bit trk, input logic inv);
    for (int i = 0; i < sync_px; i++) pix(act_hi, v, 1'b0, 24'h0, trk, inv);
    for (int i = 0; i < rest_px; i++) pix(~act_hi, v, 1'b0, 24'h0, trk, inv);
  endtask

  task automatic frame(input logic act_hi);
    for (int l = 0; l < 15; l++)
      line(act_hi, (l < 2) ? act_hi : ~act_hi, 8, 24, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic idle);
    rst_n = 1'b0; ce_pix = 1'b1; hsync = idle; vsync = idle; de = 1'b0; din = 24'h0;
    hist1 = idle; hist2 = idle;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    tests++;
    if ({dout, hsync_o, vsync_o, csync_o} !== {24'h0, 3'b111}) begin
      fails++; $display("FAIL reset_outputs: got %h want %h", {dout, hsync_o, vsync_o, csync_o}, {24'h0, 3'b111});
    end
    tests++;
    if ({h_pol, v_pol, locked} !== 3'b000) begin
      fails++; $display("FAIL reset_status: got %b want 000", {h_pol, v_pol, locked});
    end
    tests++;
    if ({dout_nb, nb_hs, nb_vs, nb_cs, nb_hp, nb_vp, nb_lk} !== {24'h0, 6'b111000}) begin
      fails++; $display("FAIL reset_nb: got %h want %h", {dout_nb, nb_hs, nb_vs, nb_cs, nb_hp, nb_vp, nb_lk}, {24'h0, 6'b111000});
    end
    repeat (3) pix(1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic test_active_low;
    line(1'b0, 1'b0, 8, 24, 1'b0, 1'b0);
    line(1'b0, 1'b0, 8, 24, 1'b0, 1'b0);
    tests++;
    if (h_pol !== 1'b0) begin fails++; $display("FAIL al_hpol_2lines: got %b want 0", h_pol); end
    for (int l = 2; l < 15; l++) line(1'b0, 1'b1, 8, 24, 1'b0, 1'b0);
    repeat (3) frame(1'b0);
    tests++;
    if ({h_pol, v_pol, locked} !== 3'b001) begin
      fails++; $display("FAIL al_lock: got %b want 001", {h_pol, v_pol, locked});
    end
    trk_err = 0;
    line(1'b0, 1'b1, 8, 24, 1'b1, 1'b0);
    tests++;
    if (trk_err !== 0) begin fails++; $display("FAIL al_hsync_track: got %0d bad pixels want 0", trk_err); end
  endtask

  task automatic test_corrupt_line;
    line(1'b0, 1'b1, 8, 1, 1'b0, 1'b0);
    line(1'b0, 1'b1, 8, 24, 1'b0, 1'b0);
    tests++;
    if (h_pol !== 1'b0) begin fails++; $display("FAIL corrupt_hpol_a: got %b want 0", h_pol); end
    line(1'b0, 1'b1, 8, 24, 1'b0, 1'b0);
    line(1'b0, 1'b1, 8, 24, 1'b0, 1'b0);
    tests++;
    if ({h_pol, locked} !== 2'b01) begin fails++; $display("FAIL corrupt_hpol_b: got %b want 01", {h_pol, locked}); end
  endtask

  // Polarities are both active-low here, so raw level 0 means asserted
  task automatic test_csync;
    logic [1:0] vin [4];
    logic [2:0] exp [4];
    vin[0] = 2'b00; exp[0] = 3'b001;
    vin[1] = 2'b10; exp[1] = 3'b100;
    vin[2] = 2'b01; exp[2] = 3'b010;
    vin[3] = 2'b11; exp[3] = 3'b111;
    for (int k = 0; k < 4; k++) begin
      repeat (3) pix(vin[k][1], vin[k][0], 1'b0, 24'h0, 1'b0, 1'b0);
      tests++;
      if ({hsync_o, vsync_o, csync_o} !== exp[k]) begin
        fails++; $display("FAIL csync_vec%0d: got %b want %b", k, {hsync_o, vsync_o, csync_o}, exp[k]);
      end
    end
  endtask

  task automatic test_blanking;
    pix(1'b1, 1'b1, 1'b0, 24'hFFFFFF, 1'b0, 1'b0);
    pix(1'b1, 1'b1, 1'b1, 24'h123456, 1'b0, 1'b0);
    pix(1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0);
    tests++;
    if (dout !== 24'h0) begin fails++; $display("FAIL blank_de0: got %h want 000000", dout); end
    tests++;
    if (dout_nb !== 24'hFFFFFF) begin fails++; $display("FAIL noblank_de0: got %h want ffffff", dout_nb); end
    @(posedge clk); #1;
    tests++;
    if (dout !== 24'h123456) begin fails++; $display("FAIL blank_de1: got %h want 123456", dout); end
    tests++;
    if (dout_nb !== 24'h123456) begin fails++; $display("FAIL noblank_de1: got %h want 123456", dout_nb); end
  endtask

  task automatic test_active_high;
    do_reset(1'b0);
    repeat (3) pix(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    line(1'b1, 1'b1, 8, 24, 1'b0, 1'b0);
    line(1'b1, 1'b1, 8, 24, 1'b0, 1'b0);
    tests++;
    if (h_pol !== 1'b1) begin fails++; $display("FAIL ah_hpol_2lines: got %b want 1", h_pol); end
    for (int l = 2; l < 15; l++) line(1'b1, 1'b0, 8, 24, 1'b0, 1'b0);
    repeat (3) frame(1'b1);
    tests++;
    if ({h_pol, v_pol, locked} !== 3'b111) begin
      fails++; $display("FAIL ah_lock: got %b want 111", {h_pol, v_pol, locked});
    end
    trk_err = 0;
    line(1'b1, 1'b0, 8, 24, 1'b1, 1'b1);
    tests++;
    if (trk_err !== 0) begin fails++; $display("FAIL ah_hsync_track: got %0d bad pixels want 0", trk_err); end
  endtask

  task automatic test_sync_loss;
    repeat (4100) pix(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    tests++;
    if ({h_pol, v_pol, locked} !== 3'b110) begin
      fails++; $display("FAIL loss_unlock: got %b want 110", {h_pol, v_pol, locked});
    end
    frame(1'b1);
    tests++;
    if ({h_pol, v_pol, locked} !== 3'b111) begin
      fails++; $display("FAIL loss_relock: got %b want 111", {h_pol, v_pol, locked});
    end
  endtask

  task automatic test_reset_midline;
    repeat (3) pix(1'b1, 1'b0, 1'b1, 24'hABCDEF, 1'b0, 1'b0);
    tests++;
    if ({dout, hsync_o, vsync_o, csync_o} !== {24'hABCDEF, 3'b010}) begin
      fails++; $display("FAIL midline_pre: got %h want %h", {dout, hsync_o, vsync_o, csync_o}, {24'hABCDEF, 3'b010});
    end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({dout, hsync_o, vsync_o, csync_o} !== {24'h0, 3'b111}) begin
      fails++; $display("FAIL midline_reset: got %h want %h", {dout, hsync_o, vsync_o, csync_o}, {24'h0, 3'b111});
    end
    tests++;
    if ({h_pol, v_pol, locked} !== 3'b000) begin
      fails++; $display("FAIL midline_status: got %b want 000", {h_pol, v_pol, locked});
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_active_low;
    test_corrupt_line;
    test_csync;
    test_blanking;
    test_active_high;
    test_sync_loss;
    test_reset_midline;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
